uart_interrupt_ctrl: RTL and testbench

Interrupt scheduler for the 16550-style UART.
- Collects the five interrupt sources: receiver line status, receiver data available, character timeout, transmitter holding register empty, modem status.
- Masks them with IER and arbitrates them by fixed 16550 priority.
- Drives the registered IIR identification code and the single interrupt line to the host.
- Owns the character-timeout counter and the THRE latch.
- Sits between the register file / FIFOs and the bus-side interrupt output.

---
 rtl/uart_interrupt_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_interrupt_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_interrupt_ctrl.sv
// 16550-style UART interrupt scheduler: latches/derives the five interrupt
// sources, masks them with IER, and drives the registered IIR code and IRQ line.
module uart_interrupt_ctrl #(
    parameter int unsigned TIMEOUT_CHARS = 4,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    ier_i,
    input  logic [1:0]                    fifo_trig_i,
    input  logic                          char_tick_i,
    input  logic [$clog2(FIFO_DEPTH):0]   rx_count_i,
    input  logic                          rx_push_i,
    input  logic                          rx_pop_i,
    input  logic                          lsr_err_i,
    input  logic                          lsr_read_i,
    input  logic                          thr_empty_i,
    input  logic                          thr_write_i,
    input  logic [3:0]                    msr_delta_i,
    input  logic                          iir_read_i,
    output logic [3:0]                    iir_o,
    output logic                          intr_o,
    output logic [4:0]                    pending_o
);

    localparam int unsigned RX_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CHARS + 1);

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_TO   = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_MS   = 4'b0000;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    logic             rls_q, rls_d;
    logic             thre_q, thre_d;
    logic             thr_empty_q;
    logic             ier_thre_q;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]       iir_q, iir_d;
    logic             intr_q, intr_d;
    logic [4:0]       pending_q, pending_d;

    logic [RX_W-1:0]  trig_c;
    logic             rda_c;
    logic             timeout_c;
    logic             ms_c;
    logic             thre_set_c;
    logic             thre_clr_c;

    // Flags are formed from latch next-states so every input reaches IIR in one cycle.
    always_comb begin
        rls_d = rls_q;
        if (lsr_read_i) rls_d = 1'b0;
        if (lsr_err_i)  rls_d = 1'b1;

        case (fifo_trig_i)
            2'b00:   trig_c = RX_W'(1);
            2'b01:   trig_c = RX_W'(4);
            2'b10:   trig_c = RX_W'(8);
            default: trig_c = RX_W'(14);
        endcase
        rda_c = (rx_count_i >= trig_c);

        to_cnt_d = to_cnt_q;
        if (rx_push_i || rx_pop_i || (rx_count_i == '0)) begin
            to_cnt_d = '0;
        end else if (char_tick_i && (to_cnt_q != CNT_W'(TIMEOUT_CHARS))) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
        timeout_c = (to_cnt_d == CNT_W'(TIMEOUT_CHARS)) && (rx_count_i != '0);

        // THRE sets on an empty rising edge or on enabling THRE while empty; clear wins.
        thre_set_c = (thr_empty_i && !thr_empty_q) || (ier_i[1] && !ier_thre_q && thr_empty_i);
        thre_clr_c = thr_write_i || (iir_read_i && (iir_q == IIR_THRE));
        thre_d     = thre_q;
        if (thre_set_c) thre_d = 1'b1;
        if (thre_clr_c) thre_d = 1'b0;

        ms_c = |msr_delta_i;

        pending_d = {ms_c, thre_d, timeout_c, rda_c, rls_d};

        if (ier_i[2] && rls_d)          iir_d = IIR_RLS;
        else if (ier_i[0] && rda_c)     iir_d = IIR_RDA;
        else if (ier_i[0] && timeout_c) iir_d = IIR_TO;
        else if (ier_i[1] && thre_d)    iir_d = IIR_THRE;
        else if (ier_i[3] && ms_c)      iir_d = IIR_MS;
        else                            iir_d = IIR_NONE;

        intr_d = (iir_d != IIR_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rls_q       <= 1'b0;
            thre_q      <= 1'b0;
            thr_empty_q <= 1'b1;
            ier_thre_q  <= 1'b0;
            to_cnt_q    <= '0;
            iir_q       <= IIR_NONE;
            intr_q      <= 1'b0;
            pending_q   <= '0;
        end else begin
            rls_q       <= rls_d;
            thre_q      <= thre_d;
            thr_empty_q <= thr_empty_i;
            ier_thre_q  <= ier_i[1];
            to_cnt_q    <= to_cnt_d;
            iir_q       <= iir_d;
            intr_q      <= intr_d;
            pending_q   <= pending_d;
        end
    end

    assign iir_o     = iir_q;
    assign intr_o    = intr_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_uart_interrupt_ctrl.sv
// Directed bench for uart_interrupt_ctrl with hand-computed IIR/IRQ expectations.
module tb_uart_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ier_i;
    logic [1:0] fifo_trig_i;
    logic       char_tick_i;
    logic [4:0] rx_count_i;
    logic       rx_push_i;
    logic       rx_pop_i;
    logic       lsr_err_i;
    logic       lsr_read_i;
    logic       thr_empty_i;
    logic       thr_write_i;
    logic [3:0] msr_delta_i;
    logic       iir_read_i;
    logic [3:0] iir_o;
    logic       intr_o;
    logic [4:0] pending_o;

    int checks = 0;
    int errors = 0;

    uart_interrupt_ctrl #(.TIMEOUT_CHARS(4), .FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ier_i       (ier_i),
        .fifo_trig_i (fifo_trig_i),
        .char_tick_i (char_tick_i),
        .rx_count_i  (rx_count_i),
        .rx_push_i   (rx_push_i),
        .rx_pop_i    (rx_pop_i),
        .lsr_err_i   (lsr_err_i),
        .lsr_read_i  (lsr_read_i),
        .thr_empty_i (thr_empty_i),
        .thr_write_i (thr_write_i),
        .msr_delta_i (msr_delta_i),
        .iir_read_i  (iir_read_i),
        .iir_o       (iir_o),
        .intr_o      (intr_o),
        .pending_o   (pending_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_iir(input string tag, input logic [3:0] exp_iir);
        check_eq({tag, "_iir"}, 8'(iir_o), 8'(exp_iir));
        check_eq({tag, "_intr"}, 8'(intr_o), 8'(exp_iir != 4'b0001));
    endtask

    initial begin
        rst = 1'b1;
        ier_i = 4'hF; fifo_trig_i = 2'b11; char_tick_i = 1'b0; rx_count_i = 5'd14;
        rx_push_i = 1'b0; rx_pop_i = 1'b0; lsr_err_i = 1'b1; lsr_read_i = 1'b0;
        thr_empty_i = 1'b0; thr_write_i = 1'b0; msr_delta_i = 4'b0001; iir_read_i = 1'b0;
        step(); step();
        check_iir("reset", 4'b0001);
        check_eq("reset_pending", 8'(pending_o), 8'd0);

        // Reset release with RLS, RDA and MS all active: RLS wins.
        rst = 1'b0;
        step();
        check_iir("rls_prio", 4'b0110);
        lsr_err_i = 1'b0;
        step();
        check_eq("rls_pending", 8'(pending_o), 8'b10011);
        lsr_read_i = 1'b1;
        step();
        lsr_read_i = 1'b0;
        check_iir("rda_after_lsr", 4'b0100);

        // RDA at trigger level 8.
        msr_delta_i = 4'b0000; ier_i = 4'b0001; fifo_trig_i = 2'b10; rx_count_i = 5'd7;
        step();
        check_iir("rda_below", 4'b0001);
        rx_count_i = 5'd8;
        step();
        check_iir("rda_at_trig", 4'b0100);
        rx_pop_i = 1'b1; rx_count_i = 5'd7;
        step();
        rx_pop_i = 1'b0;
        check_iir("rda_pop", 4'b0001);

        // Character timeout with 2 bytes below trigger 4.
        fifo_trig_i = 2'b01; rx_count_i = 5'd2;
        step();
        for (int i = 1; i <= 5; i++) begin
            char_tick_i = 1'b1;
            step();
            char_tick_i = 1'b0;
            if (i == 3) check_iir("to_tick3", 4'b0001);
            if (i == 4) check_iir("to_tick4", 4'b1100);
            if (i == 5) check_iir("to_saturate", 4'b1100);
        end
        rx_pop_i = 1'b1;
        step();
        rx_pop_i = 1'b0; rx_count_i = 5'd1;
        check_iir("to_pop", 4'b0001);
        step();
        check_iir("to_after_pop", 4'b0001);

        // THRE set by empty edge, cleared by IIR read then by THR write.
        rx_count_i = 5'd0; ier_i = 4'b0010;
        step();
        thr_empty_i = 1'b1;
        step();
        check_iir("thre_set", 4'b0010);
        iir_read_i = 1'b1;
        step();
        iir_read_i = 1'b0;
        check_iir("thre_iir_clr", 4'b0001);
        thr_empty_i = 1'b0;
        step();
        thr_empty_i = 1'b1;
        step();
        check_iir("thre_set2", 4'b0010);
        thr_write_i = 1'b1;
        step();
        thr_write_i = 1'b0;
        check_iir("thre_wr_clr", 4'b0001);

        // Set and clear in the same cycle: clear wins.
        thr_empty_i = 1'b0;
        step();
        thr_empty_i = 1'b1; thr_write_i = 1'b1;
        step();
        thr_write_i = 1'b0;
        step();
        check_iir("thre_simul", 4'b0001);
        check_eq("thre_simul_pend", 8'(pending_o[3]), 8'd0);

        // Error and LSR read together: set wins.
        ier_i = 4'b0100; lsr_err_i = 1'b1; lsr_read_i = 1'b1;
        step();
        lsr_err_i = 1'b0; lsr_read_i = 1'b0;
        step();
        check_iir("rls_simul", 4'b0110);
        lsr_read_i = 1'b1;
        step();
        lsr_read_i = 1'b0;
        check_iir("rls_clr", 4'b0001);

        // Modem status masked, then enabled, then disabled again.
        ier_i = 4'b0000; msr_delta_i = 4'b0001;
        step(); step();
        check_eq("ms_pending", 8'(pending_o), 8'b10000);
        check_iir("ms_masked", 4'b0001);
        ier_i = 4'b1000;
        step();
        check_iir("ms_enabled", 4'b0000);
        ier_i = 4'b0000;
        step();
        check_iir("ms_disabled", 4'b0001);

        // Enabling THRE while the holder is already empty raises THRE.
        msr_delta_i = 4'b0000;
        step();
        ier_i = 4'b0010;
        step();
        check_iir("thre_ier_edge", 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
